// File: rtl/cache_pkg.sv
// Shared types and helpers for the fully associative write-back cache.
// Optional statistics counters are enabled by defining CACHE_STATS_EN.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    EVICT,
    FILL,
    RESP
  } state_t;

  localparam int unsigned STAT_W = 16;

  // Way-index width; a single-entry cache still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Age a way takes out of reset: way i starts at age i, so way 0 is oldest.
  function automatic int unsigned reset_age(input int unsigned way);
    return way;
  endfunction

endpackage

// File: rtl/cache_assoc_wb_if.sv
// CPU-side req/ready bus and memory-side req/ack port of cache_assoc_wb.
interface cache_assoc_wb_if #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 8
);

  logic               req;
  logic               rw;
  logic [A_WIDTH-1:0] addr;
  logic [D_WIDTH-1:0] data_in;
  logic               ready;
  logic [D_WIDTH-1:0] data_out;
  logic               hit;

  logic               mem_req;
  logic               mem_rw;
  logic [A_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [D_WIDTH-1:0] mem_rdata;
  logic               mem_ack;

  // The cache sits on the slave side of the CPU bus and drives the memory port.
  modport slave (
    input  req, rw, addr, data_in, mem_rdata, mem_ack,
    output ready, data_out, hit, mem_req, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req, rw, addr, data_in, mem_rdata, mem_ack,
    input  ready, data_out, hit, mem_req, mem_rw, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_lru.sv
// True-LRU age tracker: ages form a permutation of 0..N_WAYS-1, age 0 is oldest.
module cache_lru
  import cache_pkg::*;
#(
  parameter  int unsigned N_WAYS = 4,
  localparam int unsigned IDX_W  = idx_w(N_WAYS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              touch_en,
  input  logic [IDX_W-1:0]  touch_idx,
  input  logic [N_WAYS-1:0] valid,
  output logic [IDX_W-1:0]  victim_idx
);

  logic [IDX_W-1:0] age [N_WAYS];

  // Touch: ways younger than the touched one slide down, touched way becomes newest.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int unsigned i = 0; i < N_WAYS; i++) begin
        age[i] <= IDX_W'(reset_age(i));
      end
    end else if (touch_en) begin
      for (int unsigned i = 0; i < N_WAYS; i++) begin
        if (IDX_W'(i) == touch_idx) begin
          age[i] <= IDX_W'(N_WAYS - 1);
        end else if (age[i] > age[touch_idx]) begin
          age[i] <= age[i] - IDX_W'(1);
        end
      end
    end
  end

  // Lowest-index invalid way takes priority over the oldest valid way.
  always_comb begin
    victim_idx = '0;
    for (int i = int'(N_WAYS) - 1; i >= 0; i--) begin
      if (age[i] == '0) victim_idx = IDX_W'(i);
    end
    for (int i = int'(N_WAYS) - 1; i >= 0; i--) begin
      if (!valid[i]) victim_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way fully associative, write-back / write-allocate cache with true-LRU and an external req/ack memory.
// Defining CACHE_STATS_EN adds saturating 16-bit hit_count / miss_count outputs.
module cache_assoc_wb
  import cache_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned N_WAYS  = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               enab,
  cache_assoc_wb_if.slave    bus
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]  hit_count,
  output logic [STAT_W-1:0]  miss_count
`endif
);

  localparam int unsigned IDX_W = idx_w(N_WAYS);

  state_t state, state_n;

  logic               rw_q;
  logic [A_WIDTH-1:0] addr_q;
  logic [D_WIDTH-1:0] wdata_q;
  logic               hit_q, hit_flag_n;
  logic [IDX_W-1:0]   vic_q;

  logic [A_WIDTH-1:0] tag  [N_WAYS];
  logic [D_WIDTH-1:0] data [N_WAYS];
  logic [N_WAYS-1:0]  valid, dirty;

  logic               ready_r, hit_r, mem_req_r, mem_rw_r;
  logic [D_WIDTH-1:0] data_out_r, mem_wdata_r;
  logic [A_WIDTH-1:0] mem_addr_r;

  logic               ready_n, hit_out_n, mem_req_n, mem_rw_n;
  logic [D_WIDTH-1:0] data_out_n, mem_wdata_n;
  logic [A_WIDTH-1:0] mem_addr_n;

  logic               accept, lookup_hit, ack_v, wr_en, touch_en;
  logic [IDX_W-1:0]   hit_idx, victim_idx, wr_idx, touch_idx;
  logic [D_WIDTH-1:0] wr_data;

  assign bus.ready     = ready_r;
  assign bus.hit       = hit_r;
  assign bus.data_out  = data_out_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_rw    = mem_rw_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  // An ack only counts while a memory request is actually outstanding.
  assign ack_v   = bus.mem_ack && mem_req_r;
  assign accept  = (state == IDLE) && enab && bus.req;
  assign wr_data = rw_q ? wdata_q : bus.mem_rdata;

  cache_lru #(.N_WAYS(N_WAYS)) u_lru (
    .clk        (clk),
    .clr        (clr),
    .touch_en   (touch_en),
    .touch_idx  (touch_idx),
    .valid      (valid),
    .victim_idx (victim_idx)
  );

  // Tag match across all ways; valid gating keeps zeroed tags from aliasing.
  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    for (int unsigned i = 0; i < N_WAYS; i++) begin
      if (valid[i] && (tag[i] == addr_q)) begin
        lookup_hit = 1'b1;
        hit_idx    = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    hit_flag_n  = hit_q;
    data_out_n  = data_out_r;
    mem_req_n   = 1'b0;
    mem_rw_n    = mem_rw_r;
    mem_addr_n  = mem_addr_r;
    mem_wdata_n = mem_wdata_r;
    wr_en       = 1'b0;
    wr_idx      = hit_idx;
    touch_en    = 1'b0;
    touch_idx   = hit_idx;
    case (state)
      IDLE: begin
        if (accept) state_n = LOOKUP;
      end
      LOOKUP: begin
        if (lookup_hit) begin
          hit_flag_n = 1'b1;
          touch_en   = 1'b1;
          state_n    = RESP;
          if (rw_q) wr_en      = 1'b1;
          else      data_out_n = data[hit_idx];
        end else begin
          hit_flag_n = 1'b0;
          if (valid[victim_idx] && dirty[victim_idx]) begin
            state_n     = EVICT;
            mem_req_n   = 1'b1;
            mem_rw_n    = 1'b1;
            mem_addr_n  = tag[victim_idx];
            mem_wdata_n = data[victim_idx];
          end else begin
            state_n = FILL;
            if (!rw_q) begin
              mem_req_n  = 1'b1;
              mem_rw_n   = 1'b0;
              mem_addr_n = addr_q;
            end
          end
        end
      end
      EVICT: begin
        if (ack_v) begin
          state_n    = FILL;
          mem_rw_n   = 1'b0;
          mem_addr_n = addr_q;
        end else begin
          mem_req_n = 1'b1;
        end
      end
      FILL: begin
        // Write misses allocate straight from the CPU data; read misses wait for memory.
        if (rw_q || ack_v) begin
          wr_en     = 1'b1;
          wr_idx    = vic_q;
          touch_en  = 1'b1;
          touch_idx = vic_q;
          state_n   = RESP;
          if (!rw_q) data_out_n = bus.mem_rdata;
        end else begin
          mem_req_n  = 1'b1;
          mem_rw_n   = 1'b0;
          mem_addr_n = addr_q;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n   = (state_n == RESP);
    hit_out_n = (state_n == RESP) && hit_flag_n;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      vic_q       <= '0;
      ready_r     <= 1'b0;
      hit_r       <= 1'b0;
      data_out_r  <= '0;
      mem_req_r   <= 1'b0;
      mem_rw_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      if (accept) begin
        rw_q    <= bus.rw;
        addr_q  <= bus.addr;
        wdata_q <= bus.data_in;
      end
      if (state == LOOKUP) vic_q <= victim_idx;
      hit_q       <= hit_flag_n;
      ready_r     <= ready_n;
      hit_r       <= hit_out_n;
      data_out_r  <= data_out_n;
      mem_req_r   <= mem_req_n;
      mem_rw_r    <= mem_rw_n;
      mem_addr_r  <= mem_addr_n;
      mem_wdata_r <= mem_wdata_n;
    end
  end

  // Line storage; clr discards everything, dirty lines included.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid <= '0;
      dirty <= '0;
      for (int unsigned i = 0; i < N_WAYS; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else if (wr_en) begin
      tag[wr_idx]   <= addr_q;
      data[wr_idx]  <= wr_data;
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= rw_q;
    end
  end

`ifdef CACHE_STATS_EN
  // One count per completed request, saturating at all-ones.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == RESP) begin
      if (hit_r) begin
        if (hit_count != '1) hit_count <= hit_count + STAT_W'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Self-checking bench for cache_assoc_wb: directed vector table, corner sequences, and
// randomized traffic scored against a recency-list cache model over a flat golden memory.
module tb_cache_assoc_wb;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned NW = 4;

  logic clk = 1'b0;
  logic clr;
  logic enab;

  always #5 clk = ~clk;

  cache_assoc_wb_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_assoc_wb #(.D_WIDTH(DW), .A_WIDTH(AW), .N_WAYS(NW)) dut (
    .clk        (clk),
    .clr        (clr),
    .enab       (enab),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- backing memory with configurable ack latency ----------------
  int unsigned mem_lat = 3;
  logic [7:0]  mem_model [256];
  logic [7:0]  wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [7:0]  rd_addr_q [$];
  int          mreq_cyc = 0;

  initial begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'hA0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end else if (bus.mem_req && clr) begin
        cnt++;
        if (cnt >= int'(mem_lat)) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_rw) begin
            mem_model[bus.mem_addr] = bus.mem_wdata;
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
          end else begin
            bus.mem_rdata = mem_model[bus.mem_addr];
            rd_addr_q.push_back(bus.mem_addr);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(posedge clk) if (bus.mem_req) mreq_cyc <= mreq_cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] gold [256];
  logic [7:0] rec_q [$];
  bit         dirty_m [256];

  task automatic model_sync();
    rec_q.delete();
    for (int i = 0; i < 256; i++) begin
      gold[i]    = mem_model[i];
      dirty_m[i] = 1'b0;
    end
  endtask

  task automatic model_access(input logic rw, input logic [7:0] a, input logic [7:0] d,
                              output logic e_hit, output int e_wb, output logic [7:0] e_wba,
                              output logic [7:0] e_wbd, output int e_rd, output logic [7:0] e_data);
    int pos;
    logic [7:0] v;
    pos = -1;
    e_wb = 0; e_wba = '0; e_wbd = '0; e_rd = 0;
    foreach (rec_q[j]) if (rec_q[j] == a) pos = j;
    e_hit = (pos >= 0);
    if (e_hit) begin
      rec_q.delete(pos);
    end else begin
      if (rec_q.size() == NW) begin
        v = rec_q.pop_front();
        if (dirty_m[v]) begin
          e_wb = 1; e_wba = v; e_wbd = gold[v];
        end
        dirty_m[v] = 1'b0;
      end
      e_rd = rw ? 0 : 1;
      dirty_m[a] = 1'b0;
    end
    rec_q.push_back(a);
    if (rw) begin
      gold[a]    = d;
      dirty_m[a] = 1'b1;
    end
    e_data = gold[a];
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  logic       r_hit;
  logic [7:0] r_data;
  int         r_cyc, n_wr, n_rd, n_mreq;
  bit         r_to;

  // One CPU transaction; cycle 1 is the cycle right after the req-sampling edge.
  task automatic txn(input logic rw_i, input logic [7:0] a, input logic [7:0] d, input int drop_at);
    int w0, rd0, m0;
    w0 = wr_addr_q.size(); rd0 = rd_addr_q.size(); m0 = mreq_cyc;
    @(negedge clk);
    bus.req = 1'b1; bus.rw = rw_i; bus.addr = a; bus.data_in = d;
    @(posedge clk);
    r_to = 1'b1; r_cyc = 0; r_hit = 1'b0; r_data = '0;
    for (int k = 1; k <= 200; k++) begin
      #1;
      if (k == drop_at) enab = 1'b0;
      if (bus.ready) begin
        r_hit = bus.hit; r_data = bus.data_out; r_cyc = k; r_to = 1'b0;
        break;
      end
      @(posedge clk);
    end
    bus.req = 1'b0;
    if (drop_at > 0) enab = 1'b1;
    @(posedge clk);
    #1;
    n_wr   = wr_addr_q.size() - w0;
    n_rd   = rd_addr_q.size() - rd0;
    n_mreq = mreq_cyc - m0;
    chk("txn_done", 32'(r_to), 0);
  endtask

  task automatic reset_dut(input bit do_chk);
    @(negedge clk);
    clr = 1'b0; bus.req = 1'b0;
    #1;
    if (do_chk) begin
      chk("rst_ready",     32'(bus.ready),     0);
      chk("rst_hit",       32'(bus.hit),       0);
      chk("rst_mem_req",   32'(bus.mem_req),   0);
      chk("rst_mem_rw",    32'(bus.mem_rw),    0);
      chk("rst_data_out",  32'(bus.data_out),  0);
      chk("rst_mem_addr",  32'(bus.mem_addr),  0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    end
    @(negedge clk); @(negedge clk);
    clr = 1'b1;
    model_sync();
    @(negedge clk);
  endtask

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_hit;
    logic [7:0] exp_rdata;
    int         exp_wr;
    logic [7:0] exp_wb_addr;
    logic [7:0] exp_wb_data;
    int         exp_rd;
  } vec_t;

  vec_t vt [7];

  initial begin
    int rc, mc;
    bit seen;
    logic       rw, e_hit;
    logic [7:0] a, d, e_wba, e_wbd, e_data;
    int         e_wb, e_rd;

    vt[0] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'h00, 0, 8'h00, 8'h00, 0};
    vt[1] = '{1'b1, 8'h11, 8'h21, 1'b0, 8'h00, 0, 8'h00, 8'h00, 0};
    vt[2] = '{1'b1, 8'h12, 8'h22, 1'b0, 8'h00, 0, 8'h00, 8'h00, 0};
    vt[3] = '{1'b1, 8'h13, 8'h23, 1'b0, 8'h00, 0, 8'h00, 8'h00, 0};
    vt[4] = '{1'b0, 8'h10, 8'h00, 1'b1, 8'h20, 0, 8'h00, 8'h00, 0};
    vt[5] = '{1'b1, 8'h14, 8'h24, 1'b0, 8'h00, 1, 8'h11, 8'h21, 0};
    vt[6] = '{1'b0, 8'h14, 8'h00, 1'b1, 8'h24, 0, 8'h00, 8'h00, 0};

    clr = 1'b1; enab = 1'b1;
    bus.req = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.data_in = '0;
    #1 clr = 1'b0;

    // Scenario 1: clean read miss, then the same address hits.
    reset_dut(1'b1);
    txn(1'b0, 8'h05, 8'h00, 0);
    chk("s1_miss_hit",   32'(r_hit),  0);
    chk("s1_miss_data",  32'(r_data), 32'h A5);
    chk("s1_miss_nrd",   32'(n_rd),   1);
    chk("s1_miss_raddr", 32'(rd_addr_q[rd_addr_q.size()-1]), 32'h05);
    chk("s1_miss_nwr",   32'(n_wr),   0);
    txn(1'b0, 8'h05, 8'h00, 0);
    chk("s1_hit_hit",    32'(r_hit),  1);
    chk("s1_hit_data",   32'(r_data), 32'h A5);
    chk("s1_hit_lat",    32'(r_cyc),  2);
    chk("s1_hit_mreq",   32'(n_mreq), 0);
`ifdef CACHE_STATS_EN
    chk("stats_hit",  32'(hit_count),  1);
    chk("stats_miss", 32'(miss_count), 1);
`endif

    // Scenario 2: vector table of allocate-on-write, LRU victim and write-back.
    reset_dut(1'b0);
    for (int i = 0; i < 7; i++) begin
      txn(vt[i].rw, vt[i].addr, vt[i].data, 0);
      chk($sformatf("vec%0d_hit", i), 32'(r_hit), 32'(vt[i].exp_hit));
      if (!vt[i].rw) chk($sformatf("vec%0d_rdata", i), 32'(r_data), 32'(vt[i].exp_rdata));
      chk($sformatf("vec%0d_nwr", i), 32'(n_wr), 32'(vt[i].exp_wr));
      if (vt[i].exp_wr > 0 && n_wr > 0) begin
        chk($sformatf("vec%0d_wb_addr", i), 32'(wr_addr_q[wr_addr_q.size()-1]), 32'(vt[i].exp_wb_addr));
        chk($sformatf("vec%0d_wb_data", i), 32'(wr_data_q[wr_data_q.size()-1]), 32'(vt[i].exp_wb_data));
      end
      chk($sformatf("vec%0d_nrd", i), 32'(n_rd), 32'(vt[i].exp_rd));
    end

    // Scenario 3: address 0 after reset must miss despite zeroed tags.
    reset_dut(1'b0);
    txn(1'b0, 8'h00, 8'h00, 0);
    chk("s3_hit",   32'(r_hit),  0);
    chk("s3_nrd",   32'(n_rd),   1);
    chk("s3_raddr", 32'(rd_addr_q[rd_addr_q.size()-1]), 32'h00);
    chk("s3_data",  32'(r_data), 32'h A0);

    // Scenario 4: clr during a stalled write-back drops everything, no write-back.
    reset_dut(1'b0);
    for (int i = 0; i < 4; i++) txn(1'b1, 8'h30 + 8'(i), 8'hC0 + 8'(i), 0);
    mem_lat = 50;
    @(negedge clk);
    bus.req = 1'b1; bus.rw = 1'b1; bus.addr = 8'h34; bus.data_in = 8'h44;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.mem_req) begin seen = 1'b1; break; end
    end
    chk("s4_evict_seen",  32'(seen),          1);
    chk("s4_evict_rw",    32'(bus.mem_rw),    1);
    chk("s4_evict_addr",  32'(bus.mem_addr),  32'h30);
    chk("s4_evict_wdata", 32'(bus.mem_wdata), 32'h C0);
    #2 clr = 1'b0;
    #1;
    chk("s4_clr_mem_req", 32'(bus.mem_req), 0);
    chk("s4_clr_ready",   32'(bus.ready),   0);
    bus.req = 1'b0;
    @(negedge clk);
    clr = 1'b1; mem_lat = 3;
    @(negedge clk);
    chk("s4_no_writeback", 32'(mem_model[8'h30]), 32'h90);
    txn(1'b0, 8'h30, 8'h00, 0);
    chk("s4_after_hit",  32'(r_hit),  0);
    chk("s4_after_data", 32'(r_data), 32'h90);
    chk("s4_after_nrd",  32'(n_rd),   1);

    // Scenario 5: enab low blocks acceptance; dropping it mid-fill does not abort.
    reset_dut(1'b0);
    enab = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 8'h40;
    rc = 0; mc = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.ready) rc++;
      if (bus.mem_req) mc++;
    end
    chk("s5_blocked_ready",   32'(rc), 0);
    chk("s5_blocked_mem_req", 32'(mc), 0);
    @(negedge clk);
    bus.req = 1'b0; enab = 1'b1;
    txn(1'b0, 8'h40, 8'h00, 3);
    chk("s5_fill_hit",  32'(r_hit),  0);
    chk("s5_fill_data", 32'(r_data), 32'h E0);

    // Randomized traffic over a small address window to force hits, evictions and write-backs.
    reset_dut(1'b0);
    for (int t = 0; t < 300; t++) begin
      rw = 1'($urandom_range(0, 1));
      a  = 8'h60 + 8'($urandom_range(0, 9));
      d  = 8'($urandom);
      mem_lat = $urandom_range(1, 4);
      model_access(rw, a, d, e_hit, e_wb, e_wba, e_wbd, e_rd, e_data);
      txn(rw, a, d, 0);
      chk("rnd_hit", 32'(r_hit), 32'(e_hit));
      if (!rw) chk("rnd_rdata", 32'(r_data), 32'(e_data));
      chk("rnd_nwr", 32'(n_wr), 32'(e_wb));
      if (e_wb > 0 && n_wr > 0) begin
        chk("rnd_wb_addr", 32'(wr_addr_q[wr_addr_q.size()-1]), 32'(e_wba));
        chk("rnd_wb_data", 32'(wr_data_q[wr_data_q.size()-1]), 32'(e_wbd));
      end
      chk("rnd_nrd", 32'(n_rd), 32'(e_rd));
      if (e_hit) begin
        chk("rnd_hit_lat",  32'(r_cyc),  2);
        chk("rnd_hit_mreq", 32'(n_mreq), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_assoc_wb.md
Name: cache_assoc_wb

Overview:
- Parametrised N-way fully associative cache with true-LRU replacement, valid/dirty bits and write-back, write-allocate policy.
- Sits between the accumulator datapath and data memory.
- Line size is one word.
- The backing store is external, reached over a req/ack memory port instead of an embedded RAM.
- CPU side uses a req/ready handshake.

Parameters:
- D_WIDTH, 8, data word width.
- A_WIDTH, 8, address width.
- N_WAYS, 4, number of entries; power of 2, >=2.
- IDX_W, $clog2(N_WAYS), derived way-index width; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- enab  in  1  chip enable; gates acceptance of new requests only.
- req  in  1  CPU request; rw/addr/data_in held stable until ready.
- rw  in  1  0=read, 1=write.
- addr  in  A_WIDTH  target address.
- data_in  in  D_WIDTH  write data.
- ready  out  1  one-cycle completion pulse.
- data_out  out  D_WIDTH  read data, valid while ready=1; holds last value otherwise.
- hit  out  1  valid with ready; 1 = request hit.
- mem_req  out  1  memory request, held until mem_ack.
- mem_rw  out  1  0=read, 1=write.
- mem_addr  out  A_WIDTH  memory address.
- mem_wdata  out  D_WIDTH  memory write data.
- mem_rdata  in  D_WIDTH  memory read data, sampled when mem_ack=1.
- mem_ack  in  1  memory completion pulse.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE.
  - ready, hit, mem_req, mem_rw = 0; data_out, mem_addr, mem_wdata = 0.
  - All valid and dirty bits = 0.
  - Way i age = i.
- States: IDLE, LOOKUP, EVICT, FILL, RESP.
- IDLE:
  - If enab=1 and req=1: latch rw/addr/data_in, go to LOOKUP.
  - Otherwise stay. enab=0 never blocks a transaction already in flight.
- LOOKUP: hit means valid[i] && tag[i]==addr; at most one way can match.
  - Hit read: data_out = data[i].
  - Hit write: data[i] = data_in, dirty[i] = 1.
  - On hit: touch i, go to RESP.
  - On miss, victim = lowest-index invalid way; if none, the way with age 0.
  - Miss with a dirty victim: go to EVICT. Otherwise go to FILL.
- EVICT:
  - mem_req=1, mem_rw=1, mem_addr=tag[victim], mem_wdata=data[victim], all held until mem_ack.
  - On mem_ack: mem_req=0, go to FILL.
- FILL:
  - Write miss: no memory access. Install tag=addr, data=data_in, valid=1, dirty=1; touch victim; go to RESP.
  - Read miss: mem_req=1, mem_rw=0, mem_addr=addr, held until mem_ack.
  - On mem_ack: install tag=addr, data=mem_rdata, valid=1, dirty=0; data_out=mem_rdata; touch victim; go to RESP.
- RESP: ready=1 and hit valid for exactly one cycle, then IDLE.
- Latency:
  - Hit: ready asserts 2 cycles after the req-sampling edge.
  - Clean read miss: 3 cycles + memory latency.
  - Dirty miss: adds one memory write.
- LRU touch of way k:
  - Every way with age > age[k] decrements.
  - age[k] = N_WAYS-1.
  - Ages stay a permutation of 0..N_WAYS-1 at all times.
- A new req is accepted no earlier than the cycle after ready.
- mem_ack while mem_req=0 is ignored.
- clr asserted mid-transaction: everything returns to reset values immediately, including mem_req dropping. Dirty data is discarded, with no write-back.
- No address aliases to a hit unless that way is valid; address 0 after reset misses.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count and miss_count, 16 bits each, cleared by clr.
  - The matching counter increments on each RESP cycle and saturates at 16'hFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_pkg holds:
  - the state enum (IDLE, LOOKUP, EVICT, FILL, RESP);
  - the index-width helper function;
  - reset-age constants.
- Sub-module cache_lru (N_WAYS parameter) holds:
  - the age registers, touch logic and victim select;
  - inputs: touch_en, touch_idx, valid vector;
  - output: victim_idx.

Test Plan:
- Reset, read 0x05, memory acks 3 cycles later with 0xA5:
  - one mem read at 0x05; ready with data_out=0xA5, hit=0.
  - Re-read 0x05: hit=1, ready 2 cycles after req, mem_req never asserted.
- Writes 0x10..0x13 with data 0x20..0x23, then read 0x10, then write 0x14:
  - no memory traffic until the 0x14 miss;
  - then a single mem write mem_addr=0x11, mem_wdata=0x21;
  - read 0x14 then hits with 0x24 written data.
- After reset, read 0x00 -> miss and mem read at 0x00; no false hit on zeroed tags.
- Pull clr low during EVICT with mem_req=1:
  - mem_req and ready drop immediately;
  - the previously cached address then misses.
- enab=0 with req=1 for 10 cycles: no ready, no mem_req. Drop enab during FILL: the transaction still completes with ready.
- With CACHE_STATS_EN, after scenario 1: hit_count=1, miss_count=1.
